// File: rtl/scmp_arbiter_if.sv
// scmp_arbiter_if: request/response bundle between the client requesters
// and the shared subtract/compare scheduler. The master drives the requests
// and rsp_ready. The slave (the arbiter) drives the grant and the response.
interface scmp_arbiter_if #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [2*NREQ-1:0]     op;
   logic [WIDTH*NREQ-1:0] a;
   logic [WIDTH*NREQ-1:0] b;
   logic [NREQ-1:0]       gnt;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic                  rsp_o;
   logic [WIDTH-1:0]      rsp_diff;

   modport master (
      output req, op, a, b, rsp_ready,
      input  gnt, rsp_valid, rsp_id, rsp_o, rsp_diff
   );

   modport slave (
      input  req, op, a, b, rsp_ready,
      output gnt, rsp_valid, rsp_id, rsp_o, rsp_diff
   );
endinterface

// File: rtl/scmp_arbiter.sv
// scmp_arbiter: round-robin scheduler that shares one signed subtractor
// (A + ~B + 1) among NREQ requesters. The subtractor returns a registered
// compare result (SGE/SLT/EQ/SGT) and the difference, using a valid/ready
// response handshake.
// Optional macro SCMP_ARB_PIPE_EN splits execution into two cycles. The
// first cycle registers the carry-chain sum. The second cycle decodes the
// flags and registers the response.
module scmp_arbiter #(
   parameter int WIDTH = 4,
   parameter int NREQ  = 4
) (
   input  logic          CLK,
   input  logic          RESET,
   scmp_arbiter_if.slave bus
);
   localparam int               IDW     = $clog2(NREQ);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [IDW-1:0]   PTR_RST = IDW'(NREQ - 1);

`ifdef SCMP_ARB_PIPE_EN
   typedef enum logic [1:0] {S_IDLE, S_EXEC0, S_EXEC1, S_DONE} state_t;
   localparam state_t S_START = S_EXEC0;
`else
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
   localparam state_t S_START = S_EXEC;
`endif

   state_t                  r_state, w_state_nx;
   logic [IDW-1:0]          r_ptr, r_id_p0, r_rsp_id, w_win;
   logic signed [WIDTH-1:0] r_a_p0, r_b_p0;
   logic [1:0]              r_op_p0;
   logic [WIDTH-1:0]        r_rsp_diff, w_d_p0;
   logic                    r_rsp_o, r_rsp_valid;
   logic                    w_found, w_can_grant, w_grant;
   logic [NREQ-1:0]         w_gnt;
`ifdef SCMP_ARB_PIPE_EN
   logic [WIDTH-1:0]        r_d_p1;
`endif

   // Subtract using inverted operand plus carry-in, so the result maps onto one carry chain
   function automatic logic [WIDTH-1:0] sub_chain(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
      return x + ~y + ONE;
   endfunction

   // Sign/overflow decode of the difference into the opcode's compare result
   function automatic logic cmp_decode(input logic signed [WIDTH-1:0] x,
                                       input logic signed [WIDTH-1:0] y,
                                       input logic [WIDTH-1:0]        d,
                                       input logic [1:0]              opc);
      logic n, v, ge, eq;
      n  = d[WIDTH-1];
      v  = (x[WIDTH-1] ^ y[WIDTH-1]) & (x[WIDTH-1] ^ n);
      ge = ~(n ^ v);
      eq = (d == '0);
      case (opc)
         2'b00:   cmp_decode = ge;
         2'b01:   cmp_decode = ~ge;
         2'b10:   cmp_decode = eq;
         default: cmp_decode = ge & ~eq;
      endcase
   endfunction

   // Round-robin search: start one past the last winner, first asserted request wins
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found && bus.req[(int'(r_ptr) + k) % NREQ]) begin
            w_found = 1'b1;
            w_win   = IDW'((int'(r_ptr) + k) % NREQ);
         end
      end
   end

   assign w_can_grant = (r_state == S_IDLE) || ((r_state == S_DONE) && bus.rsp_ready);
   assign w_grant     = w_can_grant && w_found && !RESET;
   assign w_d_p0      = sub_chain(r_a_p0, r_b_p0);

   // One-hot grant for the cycle whose edge captures the winner's operands
   always_comb begin
      w_gnt = '0;
      if (w_grant) w_gnt[w_win] = 1'b1;
   end

   // Next-state logic: one operation in flight, and DONE waits for rsp_ready
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  if (w_grant) w_state_nx = S_START;
`ifdef SCMP_ARB_PIPE_EN
         S_EXEC0: w_state_nx = S_EXEC1;
         S_EXEC1: w_state_nx = S_DONE;
`else
         S_EXEC:  w_state_nx = S_DONE;
`endif
         S_DONE:  if (bus.rsp_ready) w_state_nx = w_grant ? S_START : S_IDLE;
         default: w_state_nx = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) r_state <= S_IDLE;
      else       r_state <= w_state_nx;
   end

   // Operand latch, pointer update and response registers
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ptr       <= PTR_RST;
         r_a_p0      <= '0;
         r_b_p0      <= '0;
         r_op_p0     <= '0;
         r_id_p0     <= '0;
         r_rsp_id    <= '0;
         r_rsp_o     <= 1'b0;
         r_rsp_diff  <= '0;
         r_rsp_valid <= 1'b0;
`ifdef SCMP_ARB_PIPE_EN
         r_d_p1      <= '0;
`endif
      end else begin
         // p0: capture the granted requester's operands
         if (w_grant) begin
            r_ptr   <= w_win;
            r_id_p0 <= w_win;
            r_a_p0  <= bus.a[int'(w_win)*WIDTH +: WIDTH];
            r_b_p0  <= bus.b[int'(w_win)*WIDTH +: WIDTH];
            r_op_p0 <= bus.op[2*int'(w_win) +: 2];
         end
`ifdef SCMP_ARB_PIPE_EN
         // p1: register the carry-chain sum
         if (r_state == S_EXEC0) r_d_p1 <= w_d_p0;
         // p2: decode flags and publish the response
         if (r_state == S_EXEC1) begin
            r_rsp_diff  <= r_d_p1;
            r_rsp_o     <= cmp_decode(r_a_p0, r_b_p0, r_d_p1, r_op_p0);
            r_rsp_id    <= r_id_p0;
            r_rsp_valid <= 1'b1;
         end
`else
         // p1: subtract, decode and publish the response
         if (r_state == S_EXEC) begin
            r_rsp_diff  <= w_d_p0;
            r_rsp_o     <= cmp_decode(r_a_p0, r_b_p0, w_d_p0, r_op_p0);
            r_rsp_id    <= r_id_p0;
            r_rsp_valid <= 1'b1;
         end
`endif
         if ((r_state == S_DONE) && bus.rsp_ready) r_rsp_valid <= 1'b0;
      end
   end

   assign bus.gnt       = w_gnt;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_o     = r_rsp_o;
   assign bus.rsp_diff  = r_rsp_diff;
endmodule

// File: doc/scmp_arbiter.md
# scmp_arbiter

Round-robin scheduler sharing one signed subtract/compare datapath (inverted-operand add with carry-in 1, MSB/overflow decode) among NREQ requesters. Each requester presents two signed operands and an opcode. The block grants one requester, runs the shared subtractor, and returns a registered compare result plus difference with a tagged valid/ready response. It sits between client logic and the single iCE40 carry-chain subtractor, so only one carry chain is spent.

## Interface
- WIDTH, 4: operand width in bits, two's complement, 2..16.
- NREQ, 4: number of requesters, 2..8; IDW = clog2(NREQ).
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- req  in  NREQ  request per requester; held until granted.
- op  in  2*NREQ  opcode per requester (slice i = bits 2i+1:2i): 00 SGE, 01 SLT, 10 EQ, 11 SGT.
- a  in  WIDTH*NREQ  signed operand A per requester.
- b  in  WIDTH*NREQ  signed operand B per requester.
- gnt  out  NREQ  one-hot, combinational; high during the cycle whose rising edge captures that requester's operands.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the granted requester.
- rsp_o  out  1  compare result for the opcode.
- rsp_diff  out  WIDTH  A - B modulo 2^WIDTH.

## Operation
- States: IDLE, EXEC, DONE.
  - With SCMP_ARB_PIPE_EN only, EXEC is split into EXEC0 and EXEC1.
- Arbitration: search starts at ptr+1 and wraps modulo NREQ. The first asserted req wins. ptr is updated to the winner on grant.
- A grant may occur in IDLE, or in DONE on the same cycle that rsp_ready is high.
  - On a grant: gnt[i]=1, {a_i, b_i, op_i, i} are latched, next state is EXEC.
  - If no req is asserted, next state is IDLE.
- EXEC computes the following from the latched operands:
  - d = A + ~B + 1, truncated to WIDTH bits.
  - n = d[WIDTH-1].
  - v = (A[msb]^B[msb]) & (A[msb]^n).
  - ge = ~(n^v).
  - eq = (d==0).
- Results by opcode:
  - SGE = ge.
  - SLT = ~ge.
  - EQ = eq.
  - SGT = ge & ~eq.
- EXEC registers rsp_o, rsp_diff and rsp_id, sets rsp_valid, and moves to DONE.
- DONE holds rsp_valid and all rsp_* stable until rsp_ready=1.
  - On that edge, either a new grant is taken (→EXEC) or the block returns to IDLE, with rsp_valid cleared.
- No grant is issued in DONE while rsp_ready=0. gnt stays 0.
- A requester that drops req before being granted is simply skipped. Any req change outside its grant cycle is ignored.
- Only one operation is in flight at a time.

## Timing
- Reset (asynchronous, any state): state=IDLE, ptr=NREQ-1 (requester 0 has first priority), rsp_valid=0, rsp_o=0, rsp_diff=0, rsp_id=0, all latched operands 0. gnt=0 while RESET is high.
- Reset during EXEC or DONE abandons the operation. No response is produced.
- Request-to-response latency: grant at edge t, rsp_valid high from t+1 (t+2 with SCMP_ARB_PIPE_EN).
- Maximum throughput with rsp_ready tied high: one response per 2 cycles (3 with SCMP_ARB_PIPE_EN).
- rsp_valid is never high in the cycle after a reset deassertion.

## Configuration
- SCMP_ARB_PIPE_EN defined:
  - EXEC0 registers the carry-chain sum d.
  - EXEC1 computes the flags and registers the response.
  - Adds 1 cycle of latency and shortens the critical path for WIDTH ≥ 8.
- SCMP_ARB_PIPE_EN undefined: single EXEC cycle, with timing as stated above.
- Arbitration, handshake and result values are identical in both builds.

## Test plan
- WIDTH=4, req0 with A=-8, B=7, op=SGE → rsp_o=0, rsp_diff=4'h1, rsp_id=0. Same operands with op=SLT → rsp_o=1.
- Overflow check, A=7, B=-8, op=SGE → rsp_o=1, rsp_diff=4'hF. A=3, B=3, op=SGT → rsp_o=0. A=3, B=3, op=EQ → rsp_o=1.
- All four req held high, rsp_ready=1 → grant order 0,1,2,3,0. With SCMP_ARB_PIPE_EN undefined, gnt pulses are exactly 2 cycles apart.
- Response backpressure: rsp_valid set, rsp_ready=0 for 5 cycles while req2 is high → rsp_* stable and gnt=0 throughout. When rsp_ready=1, req2 is granted in that same cycle.
- RESET asserted mid-EXEC → rsp_valid=0 and ptr=NREQ-1 immediately. After release with req1 and req3 high, req1 is granted first.
- req1 raised then dropped while another operation is in DONE with rsp_ready=0 → req1 is never granted and no response with rsp_id=1 appears.
